// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// uart_tx_sched : buffers MMIO UART store bytes in a FIFO and issues them to
//                 the transmitter under valid/ready, flagging dropped writes.
// Revision     : 1.0
// ============================================================================
module uart_tx_sched #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en_i,
   input  logic [7:0]    wr_data_i,
   input  logic          tx_ready_i,
   output logic          tx_valid_o,
   output logic [7:0]    tx_data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o,
   output logic          overflow_o,
   input  logic          ovf_clr_i
);

   localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0] C_ONE   = (AW+1)'(1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          tx_valid_q, tx_valid_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          ovf_q, ovf_d;

   logic          w_empty;
   logic          w_full;
   logic          w_load;
   logic          w_wr_acc;
   logic          w_drop;

   assign w_empty = (count_q == '0);
   assign w_full  = (count_q == C_DEPTH);

   // Issue FSM: a load moves the FIFO head into tx_data; tx_ready only matters in SEND.
   always_comb begin
      state_d    = state_q;
      tx_valid_d = tx_valid_q;
      w_load     = 1'b0;
      if (state_q == S_IDLE) begin
         if (!w_empty) begin
            w_load     = 1'b1;
            tx_valid_d = 1'b1;
            state_d    = S_SEND;
         end
      end else begin
         if (tx_ready_i) begin
            if (!w_empty) begin
               w_load = 1'b1;
            end else begin
               tx_valid_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
      end
   end

   // A full FIFO still accepts a write when a load frees the head slot this cycle.
   always_comb begin
      w_wr_acc  = wr_en_i & (!w_full | w_load);
      w_drop    = wr_en_i & !w_wr_acc;
      wr_ptr_d  = wr_ptr_q + AW'(w_wr_acc);
      rd_ptr_d  = rd_ptr_q + AW'(w_load);
      tx_data_d = w_load ? mem_q[rd_ptr_q] : tx_data_q;
      count_d   = count_q;
      case ({w_wr_acc, w_load})
         2'b10:   count_d = count_q + C_ONE;
         2'b01:   count_d = count_q - C_ONE;
         default: count_d = count_q;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr_i) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         ovf_q      <= ovf_d;
      end
   end

   // Storage array carries no reset; occupancy is governed by count and pointers.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   assign tx_valid_o = tx_valid_q;
   assign tx_data_o  = tx_data_q;
   assign full_o     = w_full;
   assign empty_o    = w_empty;
   assign count_o    = count_q;
   assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_sched : directed table-driven bench for uart_tx_sched
// Revision         : 1.0
// ============================================================================
module tb_uart_tx_sched;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          tx_ready;
   logic          ovf_clr;
   logic          tx_valid;
   logic [7:0]    tx_data;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   uart_tx_sched #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (wr_en),
      .wr_data_i  (wr_data),
      .tx_ready_i (tx_ready),
      .tx_valid_o (tx_valid),
      .tx_data_o  (tx_data),
      .full_o     (full),
      .empty_o    (empty),
      .count_o    (count),
      .overflow_o (overflow),
      .ovf_clr_i  (ovf_clr)
   );

   typedef struct {
      logic       wr;
      logic [7:0] d;
      logic       rdy;
      logic       clr;
      logic       ev;
      logic [7:0] ed;
      int         ec;
      logic       eo;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic wr, input logic [7:0] d, input logic rdy,
                               input logic clr, input logic ev, input logic [7:0] ed,
                               input int ec, input logic eo);
      vec_t v;
      v.wr = wr; v.d = d; v.rdy = rdy; v.clr = clr;
      v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo;
      vq.push_back(v);
   endfunction

   task automatic chk(input string name, input string tag, input int row,
                      input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s %s row %0d: got %0h expected %0h", tag, name, row, got, exp);
   endtask

   task automatic check_all(input string tag, input int row, input logic ev,
                            input logic [7:0] ed, input int ec, input logic eo);
      chk("tx_valid", tag, row, 32'(tx_valid), 32'(ev));
      chk("tx_data",  tag, row, 32'(tx_data),  32'(ed));
      chk("count",    tag, row, 32'(count),    32'(ec));
      chk("full",     tag, row, 32'(full),     32'(ec == DEPTH));
      chk("empty",    tag, row, 32'(empty),    32'(ec == 0));
      chk("overflow", tag, row, 32'(overflow), 32'(eo));
   endtask

   task automatic run_table(input string tag);
      foreach (vq[i]) begin
         wr_en    = vq[i].wr;
         wr_data  = vq[i].d;
         tx_ready = vq[i].rdy;
         ovf_clr  = vq[i].clr;
         @(posedge clk);
         #1;
         check_all(tag, i, vq[i].ev, vq[i].ed, vq[i].ec, vq[i].eo);
      end
      vq.delete();
      wr_en   = 1'b0;
      ovf_clr = 1'b0;
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] prev;
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      wr_data  = 8'h00;
      tx_ready = 1'b0;
      ovf_clr  = 1'b0;
      #12;
      check_all("por", 0, 1'b0, 8'h00, 0, 1'b0);
      #1 rst_n = 1'b1;

      // Mid-burst state: five queued, one offered.
      for (int k = 0; k < 6; k++)
         add(1'b1, 8'(k + 1), 1'b0, 1'b0, k >= 1, (k >= 1) ? 8'h01 : 8'h00, (k == 0) ? 1 : k, 1'b0);
      run_table("burst");

      #2 rst_n = 1'b0;
      #1;
      check_all("async_rst", 0, 1'b0, 8'h00, 0, 1'b0);
      tx_ready = 1'b1;
      #3 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0);
      run_table("post_rst");

      add(1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h41, 0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 0, 1'b0);
      run_table("single");

      add(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h41, 1, 1'b0);
      add(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h10, 1, 1'b0);
      add(1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 8'h10, 2, 1'b0);
      add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h10, 2, 1'b0);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 1, 1'b0);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h12, 0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h12, 0, 1'b0);
      run_table("backpressure");

      // 18 writes under backpressure: byte 17 is the only one lost.
      add(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h12, 1, 1'b0);
      for (int k = 1; k < 18; k++)
         add(1'b1, 8'(k), 1'b0, 1'b0, 1'b1, 8'h00, (k > 16) ? 16 : k, k == 17);
      for (int j = 1; j <= 16; j++)
         add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'(j), 16 - j, 1'b1);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 0, 1'b1);
      add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h10, 0, 1'b0);
      run_table("overflow");

      add(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h10, 1, 1'b0);
      for (int k = 1; k <= 16; k++)
         add(1'b1, 8'(8'h20 + k), 1'b0, 1'b0, 1'b1, 8'h20, k, 1'b0);
      add(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 8'h21, 16, 1'b0);
      for (int j = 1; j <= 16; j++)
         add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, (j < 16) ? 8'(8'h21 + j) : 8'hAA, 16 - j, 1'b0);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hAA, 0, 1'b0);
      run_table("full_simul");

      add(1'b1, 8'h50, 1'b0, 1'b0, 1'b0, 8'hAA, 1, 1'b0);
      for (int k = 1; k <= 16; k++)
         add(1'b1, 8'(8'h50 + k), 1'b0, 1'b0, 1'b1, 8'h50, k, 1'b0);
      add(1'b1, 8'h61, 1'b0, 1'b0, 1'b1, 8'h50, 16, 1'b1);
      add(1'b1, 8'h62, 1'b0, 1'b1, 1'b1, 8'h50, 16, 1'b1);
      add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h50, 16, 1'b0);
      for (int j = 1; j <= 16; j++)
         add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'(8'h50 + j), 16 - j, 1'b0);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h60, 0, 1'b0);
      run_table("ovf_clr");

      // 40-byte stream at full rate wraps both pointers twice.
      prev = 8'h60;
      for (int i = 0; i < 40; i++) begin
         b = 8'(i * 7 + 3);
         add(1'b1, b, 1'b1, 1'b0, i > 0, prev, 1, 1'b0);
         prev = b;
      end
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, prev, 0, 1'b0);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, prev, 0, 1'b0);
      run_table("wrap");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
